keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low rows, samples synchronized columns, publishes 16-bit key frames.
// Optional build macro KEYPAD_SCANNER_GHOST_REJECT_EN blanks any published frame holding two or more keys.
module keypad_scanner #(
   parameter int SETTLE_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic [3:0]  col_n,
   output logic [3:0]  row_n,
   output logic [15:0] keypad_raw,
   output logic        frame_valid,
   output logic        multi_key,
   output logic        scan_busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, PUBLISH} state_t;

   localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [1:0]  row_idx;
   logic [19:0] settle_cnt;
   logic [3:0]  col_sync_p0;
   logic [3:0]  col_sync_p1;
   logic [15:0] frame;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   function automatic logic [3:0] row_drive(input logic [1:0] idx);
      logic [3:0] v;
      v      = 4'hF;
      v[idx] = 1'b0;
      return v;
   endfunction

   function automatic logic [15:0] publish_value(input logic [15:0] v);
`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
      return (popcount16(v) >= 5'd2) ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // Stage p0/p1: two-flop synchronizer on the asynchronous column inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_sync_p0 <= 4'hF;
         col_sync_p1 <= 4'hF;
      end else begin
         col_sync_p0 <= col_n;
         col_sync_p1 <= col_sync_p0;
      end
   end

   // Frame assembly: one nibble per row, loaded on the exit edge of SAMPLE
   always_ff @(posedge clk) begin
      if (state == SAMPLE) frame[{row_idx, 2'b00} +: 4] <= ~col_sync_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         row_idx     <= 2'd0;
         settle_cnt  <= 20'd0;
         row_n       <= 4'hF;
         keypad_raw  <= 16'h0000;
         frame_valid <= 1'b0;
         multi_key   <= 1'b0;
         scan_busy   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            IDLE: begin
               row_n <= 4'hF;
               if (scan_en) begin
                  state      <= DRIVE;
                  row_idx    <= 2'd0;
                  settle_cnt <= 20'd0;
                  row_n      <= row_drive(2'd0);
                  scan_busy  <= 1'b1;
               end
            end
            DRIVE: begin
               if (!scan_en) begin
                  state      <= IDLE;
                  row_idx    <= 2'd0;
                  settle_cnt <= 20'd0;
                  row_n      <= 4'hF;
                  keypad_raw <= 16'h0000;
                  scan_busy  <= 1'b0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 20'd1;
               end
            end
            SAMPLE: begin
               if (!scan_en) begin
                  state      <= IDLE;
                  row_idx    <= 2'd0;
                  settle_cnt <= 20'd0;
                  row_n      <= 4'hF;
                  keypad_raw <= 16'h0000;
                  scan_busy  <= 1'b0;
               end else if (row_idx != 2'd3) begin
                  state      <= DRIVE;
                  row_idx    <= row_idx + 2'd1;
                  settle_cnt <= 20'd0;
                  row_n      <= row_drive(row_idx + 2'd1);
               end else begin
                  state <= PUBLISH;
                  row_n <= 4'hF;
               end
            end
            PUBLISH: begin
               // The publish always completes; scan_en only picks the next state
               keypad_raw  <= publish_value(frame);
               multi_key   <= (popcount16(frame) >= 5'd2);
               frame_valid <= 1'b1;
               row_idx     <= 2'd0;
               settle_cnt  <= 20'd0;
               if (scan_en) begin
                  state <= DRIVE;
                  row_n <= row_drive(2'd0);
               end else begin
                  state     <= IDLE;
                  row_n     <= 4'hF;
                  scan_busy <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               row_n     <= 4'hF;
               scan_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: ideal keypad model, directed table, random frames and corner sequences.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scan_en;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [15:0] keypad_raw;
   logic        frame_valid;
   logic        multi_key;
   logic        scan_busy;

   logic [15:0] keys;
   logic [3:0]  glitch;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int fv_seen;

`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [15:0] keys;
      logic [15:0] exp_raw;
      logic        exp_multi;
   } vec_t;

   vec_t vecs[7];
   logic [3:0] walk[4];

   keypad_scanner #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .col_n(col_n),
      .row_n(row_n), .keypad_raw(keypad_raw), .frame_valid(frame_valid),
      .multi_key(multi_key), .scan_busy(scan_busy)
   );

   always #5 clk = ~clk;

   // Ideal keypad: a column reads low when a pressed key sits on the driven row
   always_comb begin
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if (!row_n[r] && keys[r*4+k]) c[k] = 1'b0;
      col_n = c & ~glitch;
   end

   function automatic logic [15:0] ref_raw(input logic [15:0] k);
      if (GHOST && $countones(k) >= 2) return 16'h0000;
      return k;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fv(input int max, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!frame_valid && cycles < max);
      if (!frame_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_valid timeout: got none after %0d cycles, expected a pulse", cycles);
      end
   endtask

   task automatic wait_row(input logic [3:0] target, input int max);
      int n;
      n = 0;
      while (row_n !== target && n < max) begin
         tick();
         n++;
      end
      check("wait_row reached", 32'(row_n), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"no_keys",   16'h0000, 16'h0000, 1'b0};
      vecs[1] = '{"r1c2",      16'h0040, 16'h0040, 1'b0};
      vecs[2] = '{"r0c0_r3c3", 16'h8001, GHOST ? 16'h0000 : 16'h8001, 1'b1};
      vecs[3] = '{"r2c1",      16'h0200, 16'h0200, 1'b0};
      vecs[4] = '{"r3_pair",   16'h3000, GHOST ? 16'h0000 : 16'h3000, 1'b1};
      vecs[5] = '{"all_keys",  16'hFFFF, GHOST ? 16'h0000 : 16'hFFFF, 1'b1};
      vecs[6] = '{"r3c0",      16'h1000, 16'h1000, 1'b0};
      walk[0] = 4'hE; walk[1] = 4'hD; walk[2] = 4'hB; walk[3] = 4'h7;

      rst_n = 1'b0; scan_en = 1'b0; keys = 16'h0; glitch = 4'h0;
      #12;
      check("rst row_n", 32'(row_n), 32'hF);
      check("rst keypad_raw", 32'(keypad_raw), 32'h0);
      check("rst frame_valid", 32'(frame_valid), 32'h0);
      check("rst multi_key", 32'(multi_key), 32'h0);
      check("rst scan_busy", 32'(scan_busy), 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) tick();
      check("idle row_n", 32'(row_n), 32'hF);
      check("idle scan_busy", 32'(scan_busy), 32'h0);

      // Row walk with no keys
      scan_en = 1'b1;
      wait_row(4'hE, 5);
      for (int i = 0; i < 21; i++) begin
         check($sformatf("walk row_n[%0d]", i), 32'(row_n), 32'((i < 20) ? walk[i/5] : 4'hF));
         check($sformatf("walk fv[%0d]", i), 32'(frame_valid), 32'h0);
         if (i != 0) tick();
         else tick();
      end
      check("walk fv after 21", 32'(frame_valid), 32'h1);
      check("walk row_n restart", 32'(row_n), 32'hE);
      check("walk keypad_raw", 32'(keypad_raw), 32'h0);
      check("walk multi_key", 32'(multi_key), 32'h0);
      check("walk scan_busy", 32'(scan_busy), 32'h1);

      // Directed table: each vector is applied at a frame_valid and read at the next
      for (int i = 0; i < 7; i++) begin
         keys = vecs[i].keys;
         wait_fv(30, cyc);
         check({vecs[i].name, " period"}, 32'(cyc), 32'd21);
         check({vecs[i].name, " keypad_raw"}, 32'(keypad_raw), 32'(vecs[i].exp_raw));
         check({vecs[i].name, " multi_key"}, 32'(multi_key), 32'(vecs[i].exp_multi));
      end

      // Random frames against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [15:0] k;
         logic [15:0] one;
         one = 16'h1;
         case ($urandom_range(0, 3))
            0: k = 16'h0;
            1: k = one << $urandom_range(0, 15);
            2: k = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            default: k = 16'($urandom);
         endcase
         keys = k;
         wait_fv(30, cyc);
         check($sformatf("rand%0d period", i), 32'(cyc), 32'd21);
         check($sformatf("rand%0d keypad_raw k=%h", i, k), 32'(keypad_raw), 32'(ref_raw(k)));
         check($sformatf("rand%0d multi_key k=%h", i, k), 32'(multi_key), 32'($countones(k) >= 2));
      end

      // One-cycle column glitch early in row 1 drive must not register
      keys = 16'h0;
      wait_fv(30, cyc);
      wait_row(4'hD, 10);
      glitch = 4'b0100;
      tick();
      glitch = 4'h0;
      wait_fv(30, cyc);
      check("glitch keypad_raw", 32'(keypad_raw), 32'h0);

      // Abort during row 2 drive
      keys = 16'h0040;
      wait_fv(30, cyc);
      check("pre-abort keypad_raw", 32'(keypad_raw), 32'h0040);
      wait_row(4'hB, 15);
      scan_en = 1'b0;
      tick();
      check("abort row_n", 32'(row_n), 32'hF);
      check("abort scan_busy", 32'(scan_busy), 32'h0);
      check("abort keypad_raw", 32'(keypad_raw), 32'h0);
      fv_seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (frame_valid) fv_seen++;
         tick();
      end
      check("abort no frame_valid", 32'(fv_seen), 32'h0);
      check("abort row_n idle", 32'(row_n), 32'hF);

      // Restart from idle: first frame lands 22 edges after scan_en
      scan_en = 1'b1;
      wait_fv(40, cyc);
      check("restart latency", 32'(cyc), 32'd22);
      check("restart keypad_raw", 32'(keypad_raw), 32'h0040);

      // Asynchronous reset while sampling row 0 with a key held
      repeat (4) tick();
      check("pre-reset row_n", 32'(row_n), 32'hE);
      #2 rst_n = 1'b0;
      #1;
      check("async rst row_n", 32'(row_n), 32'hF);
      check("async rst keypad_raw", 32'(keypad_raw), 32'h0);
      check("async rst frame_valid", 32'(frame_valid), 32'h0);
      check("async rst multi_key", 32'(multi_key), 32'h0);
      check("async rst scan_busy", 32'(scan_busy), 32'h0);
      tick();
      check("held rst row_n", 32'(row_n), 32'hF);
      #3 rst_n = 1'b1;
      wait_fv(40, cyc);
      check("post-rst fv latency in 21..23", 32'(cyc >= 21 && cyc <= 23), 32'h1);
      check("post-rst keypad_raw", 32'(keypad_raw), 32'h0040);
      check("post-rst multi_key", 32'(multi_key), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
